core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
//  Shares one downstream memory port between the core's instruction (imem)
//  and data (dmem) requesters. Used for single-port SoC integration of
//  core_top. Arbitration is zero-latency. Once the downstream port is
//  presented with a request, ownership locks until that request is granted.
//  Data side has priority; a starvation counter bounds instruction-fetch wait.
// PARAMETERS
//  MEM_ADDR_W  64  address width (all ports)
//  MEM_STRB_W   8  write strobe width
//  MEM_DATA_W  64  data width
//  STARVE_MAX   4  consecutive dmem grants while imem waits before imem is forced to win (1..15)
// PORTS
//  f_clk       in   1           global clock
//  g_resetn    in   1           asynchronous active-low reset
//  imem_req/addr/wen/strb/wdata in  1/A/1/S/D   instruction-side request
//  imem_gnt    out  1           instruction-side response valid
//  imem_err    out  1           instruction-side response error
//  imem_rdata  out  D           instruction-side read data
//  dmem_req/addr/wen/strb/wdata in  1/A/1/S/D   data-side request
//  dmem_gnt    out  1           data-side response valid
//  dmem_err    out  1           data-side response error
//  dmem_rdata  out  D           data-side read data
//  mem_req/addr/wen/strb/wdata  out 1/A/1/S/D   downstream request
//  mem_gnt     in   1           downstream response valid
//  mem_err     in   1           downstream response error
//  mem_rdata   in   D           downstream read data
//  arb_owner   out  2           00 none, 01 imem, 10 dmem (current mux select)
// BEHAVIOUR
//  Protocol on every port:
//   - req is held, with fields stable, until gnt.
//   - The transfer completes in the cycle req&&gnt.
//   - rdata and err are valid only in that cycle.
//  FSM states: IDLE, LOCK_I, LOCK_D. Reset to IDLE, starve_ctr=0.
//  IDLE:
//   - Winner is chosen combinationally in the same cycle.
//   - dmem wins if dmem_req and !(imem_req && starve_ctr>=STARVE_MAX).
//   - Otherwise imem wins if imem_req.
//   - The winner's fields drive mem_*, mem_req=1, and arb_owner=winner.
//   - If mem_gnt: the winner's gnt=1 and the FSM stays IDLE.
//   - Else: go to LOCK_I or LOCK_D (zero added latency).
//  LOCK_x:
//   - mem_* is muxed from x only; the other requester is ignored, its gnt=0.
//   - On mem_gnt: x_gnt=1 and return to IDLE.
//   - Rearbitration happens in the following cycle, never the same cycle.
//  Outputs:
//   - Non-owner gnt and err are 0.
//   - x_err = mem_err && mem_gnt && owner==x.
//   - mem_rdata fans out to both rdata ports unmodified.
//  With no request, mem_* = 0 and arb_owner=00.
//  starve_ctr (4b), updated on each completed transfer:
//   - dmem completes while imem_req=1: increment, saturating at STARVE_MAX.
//   - imem completes, or imem_req=0 at a completion: clear to 0.
//  Simultaneous requests in IDLE resolve by the rule above. There is no
//  round-robin beyond the starvation rule.
//  Owner drops req before gnt (protocol violation): the lock is still held.
//  mem_req follows the owner's req. The bench asserts this never happens.
//  While g_resetn=0:
//   - mem_req, imem_gnt, dmem_gnt and arb_owner are forced to 0.
//  Reset mid-transfer: the lock is dropped immediately and state=IDLE.
//  After reset: first arbitration is in the first cycle with g_resetn=1.
// TESTING
//  1 imem_req only, addr=0x1000, mem_gnt=1 same cycle -> mem_addr=0x1000,
//    imem_gnt=1 cycle 0, FSM stays IDLE.
//  2 imem+dmem req together, dmem_addr=0x2000 -> dmem wins, mem_addr=0x2000;
//    imem_gnt=0 until dmem_gnt.
//  3 dmem wins, mem_gnt withheld 3 cycles; imem_req rises in cycle 1 ->
//    arb_owner=10 throughout, dmem_gnt cycle 3, imem served from cycle 4.
//  4 dmem back-to-back, imem_req held, STARVE_MAX=4 -> 4 dmem grants,
//    5th arbitration to imem, then starve_ctr=0.
//  5 mem_err=1 with mem_gnt on an imem transfer -> imem_err=1, dmem_err=0;
//    mem_rdata=0xDEADBEEF seen on imem_rdata.
//  6 g_resetn=0 during LOCK_D -> mem_req=0 at once. After release with only
//    imem_req=1 -> arb_owner=01 in the first cycle.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one downstream memory port between imem and dmem requesters
//   f_clk_i/g_resetn_i          clock, asynchronous active-low reset
//   imem_*_i / imem_*_o         instruction-side request in, gnt/err/rdata out
//   dmem_*_i / dmem_*_o         data-side request in, gnt/err/rdata out
//   mem_*_o / mem_*_i           downstream request out, gnt/err/rdata in
//   arb_owner_o                 00 none, 01 imem, 10 dmem
module core_mem_arbiter #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_STRB_W = 8,
    parameter int MEM_DATA_W = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  f_clk_i,
    input  logic                  g_resetn_i,
    input  logic                  imem_req_i,
    input  logic [MEM_ADDR_W-1:0] imem_addr_i,
    input  logic                  imem_wen_i,
    input  logic [MEM_STRB_W-1:0] imem_strb_i,
    input  logic [MEM_DATA_W-1:0] imem_wdata_i,
    output logic                  imem_gnt_o,
    output logic                  imem_err_o,
    output logic [MEM_DATA_W-1:0] imem_rdata_o,
    input  logic                  dmem_req_i,
    input  logic [MEM_ADDR_W-1:0] dmem_addr_i,
    input  logic                  dmem_wen_i,
    input  logic [MEM_STRB_W-1:0] dmem_strb_i,
    input  logic [MEM_DATA_W-1:0] dmem_wdata_i,
    output logic                  dmem_gnt_o,
    output logic                  dmem_err_o,
    output logic [MEM_DATA_W-1:0] dmem_rdata_o,
    output logic                  mem_req_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic                  mem_wen_o,
    output logic [MEM_STRB_W-1:0] mem_strb_o,
    output logic [MEM_DATA_W-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_err_i,
    input  logic [MEM_DATA_W-1:0] mem_rdata_i,
    output logic [1:0]            arb_owner_o
);
    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic [1:0] owner;
    logic       pick_d, done;
    always_comb begin
        pick_d = dmem_req_i && !(imem_req_i && starve_q >= SMAX);
        owner = 2'b00;
        // Owner is forced to none in reset so every mux below collapses to zero.
        if (g_resetn_i)
            owner = state_q == LOCK_I ? 2'b01 : state_q == LOCK_D ? 2'b10 :
                    pick_d ? 2'b10 : imem_req_i ? 2'b01 : 2'b00;
        mem_req_o   = owner[0] ? imem_req_i   : owner[1] ? dmem_req_i   : 1'b0;
        mem_addr_o  = owner[0] ? imem_addr_i  : owner[1] ? dmem_addr_i  : '0;
        mem_wen_o   = owner[0] ? imem_wen_i   : owner[1] ? dmem_wen_i   : 1'b0;
        mem_strb_o  = owner[0] ? imem_strb_i  : owner[1] ? dmem_strb_i  : '0;
        mem_wdata_o = owner[0] ? imem_wdata_i : owner[1] ? dmem_wdata_i : '0;
        done = mem_req_o && mem_gnt_i;
        imem_gnt_o = done && owner[0];
        dmem_gnt_o = done && owner[1];
        imem_err_o = imem_gnt_o && mem_err_i;
        dmem_err_o = dmem_gnt_o && mem_err_i;
        // A lock persists even if the owner withdraws req; only a completion releases it.
        state_d = done ? IDLE : owner[0] ? LOCK_I : owner[1] ? LOCK_D : IDLE;
        starve_d = !done ? starve_q :
                   (owner[1] && imem_req_i) ? (starve_q >= SMAX ? SMAX : starve_q + 4'd1) : 4'd0;
    end
    assign arb_owner_o  = owner;
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;
    always_ff @(posedge f_clk_i or negedge g_resetn_i) begin
        if (!g_resetn_i) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed and randomized checks of core_mem_arbiter against a transaction-level model
module tb_core_mem_arbiter;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        ireq = 0, iwen = 0, dreq = 0, dwen = 0, mgnt = 0, merr = 0;
    logic [63:0] iaddr = 0, iwdata = 0, daddr = 0, dwdata = 0, mrdata = 0;
    logic [7:0]  istrb = 0, dstrb = 0;
    logic        igao, ierr, dgnt, derr, mreq, mwen;
    logic [63:0] irdata, drdata, maddr, mwdata;
    logic [7:0]  mstrb;
    logic [1:0]  owner;
    int pass_cnt = 0, total = 0;
    int m_hold = 0, m_starve = 0, e_own = 0;
    bit e_done = 0;

    core_mem_arbiter dut (
        .f_clk_i(clk), .g_resetn_i(rstn),
        .imem_req_i(ireq), .imem_addr_i(iaddr), .imem_wen_i(iwen), .imem_strb_i(istrb),
        .imem_wdata_i(iwdata), .imem_gnt_o(igao), .imem_err_o(ierr), .imem_rdata_o(irdata),
        .dmem_req_i(dreq), .dmem_addr_i(daddr), .dmem_wen_i(dwen), .dmem_strb_i(dstrb),
        .dmem_wdata_i(dwdata), .dmem_gnt_o(dgnt), .dmem_err_o(derr), .dmem_rdata_o(drdata),
        .mem_req_o(mreq), .mem_addr_o(maddr), .mem_wen_o(mwen), .mem_strb_o(mstrb),
        .mem_wdata_o(mwdata), .mem_gnt_i(mgnt), .mem_err_i(merr), .mem_rdata_i(mrdata),
        .arb_owner_o(owner));

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference: who is served this cycle, given who (if anyone) holds the port.
    task automatic check();
        int own;
        bit r;
        own = !rstn ? 0 : m_hold != 0 ? m_hold :
              (dreq && !(ireq && m_starve >= 4)) ? 2 : ireq ? 1 : 0;
        r = own == 1 ? ireq : own == 2 ? dreq : 1'b0;
        e_own = own;
        e_done = r && mgnt;
        cmp("arb_owner", 64'(owner), 64'(own));
        cmp("mem_req", 64'(mreq), 64'(r));
        cmp("imem_gnt", 64'(igao), 64'(e_done && own == 1));
        cmp("dmem_gnt", 64'(dgnt), 64'(e_done && own == 2));
        cmp("imem_err", 64'(ierr), 64'(e_done && own == 1 && merr));
        cmp("dmem_err", 64'(derr), 64'(e_done && own == 2 && merr));
        cmp("imem_rdata", irdata, mrdata);
        cmp("dmem_rdata", drdata, mrdata);
        if (rstn) begin
            cmp("mem_addr", maddr, own == 1 ? iaddr : own == 2 ? daddr : 64'd0);
            cmp("mem_wdata", mwdata, own == 1 ? iwdata : own == 2 ? dwdata : 64'd0);
            cmp("mem_strb", 64'(mstrb), 64'(own == 1 ? istrb : own == 2 ? dstrb : 8'd0));
            cmp("mem_wen", 64'(mwen), 64'(own == 1 ? iwen : own == 2 ? dwen : 1'b0));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check();
        @(posedge clk);
        if (!rstn) begin
            m_hold = 0;
            m_starve = 0;
        end else if (e_done) begin
            m_starve = (e_own == 2 && ireq) ? (m_starve >= 4 ? 4 : m_starve + 1) : 0;
            m_hold = 0;
        end else m_hold = e_own;
        #1;
    endtask

    task automatic lit();
        #2;
    endtask

    initial begin
        int k;
        repeat (2) cyc();
        cmp("reset_owner", 64'(owner), 64'd0);
        rstn = 1;
        // 1: imem alone, granted same cycle
        ireq = 1; iaddr = 64'h1000; mgnt = 1;
        lit();
        cmp("t1_addr", maddr, 64'h1000);
        cmp("t1_igao", 64'(igao), 64'd1);
        cyc();
        ireq = 0; mgnt = 0;
        // 2: simultaneous, dmem wins
        ireq = 1; iaddr = 64'h1100; dreq = 1; daddr = 64'h2000;
        lit();
        cmp("t2_addr", maddr, 64'h2000);
        cmp("t2_owner", 64'(owner), 64'd2);
        cyc();
        mgnt = 1;
        lit();
        cmp("t2_dgnt", 64'(dgnt), 64'd1);
        cmp("t2_igao", 64'(igao), 64'd0);
        cyc();
        dreq = 0;
        cyc();
        ireq = 0; mgnt = 0;
        // 3: dmem locked 3 cycles, imem arrives in cycle 1
        dreq = 1; daddr = 64'h3000;
        cyc();
        ireq = 1; iaddr = 64'h1200;
        cyc();
        lit();
        cmp("t3_owner_c2", 64'(owner), 64'd2);
        cyc();
        mgnt = 1;
        lit();
        cmp("t3_dgnt_c3", 64'(dgnt), 64'd1);
        cyc();
        dreq = 0;
        lit();
        cmp("t3_owner_c4", 64'(owner), 64'd1);
        cmp("t3_igao_c4", 64'(igao), 64'd1);
        cyc();
        ireq = 0;
        // 4: starvation bound
        ireq = 1; dreq = 1; mgnt = 1; k = 0;
        for (int i = 0; i < 10; i++) begin
            lit();
            if (igao) break;
            if (dgnt) k++;
            cyc();
        end
        cmp("t4_dgrants", 64'(k), 64'd4);
        cyc();
        lit();
        cmp("t4_owner_after", 64'(owner), 64'd2);
        cyc();
        ireq = 0; dreq = 0; mgnt = 0;
        // 5: error and read data routing
        ireq = 1; mgnt = 1; merr = 1; mrdata = 64'hDEADBEEF;
        lit();
        cmp("t5_ierr", 64'(ierr), 64'd1);
        cmp("t5_derr", 64'(derr), 64'd0);
        cmp("t5_rdata", irdata, 64'hDEADBEEF);
        cyc();
        ireq = 0; mgnt = 0; merr = 0;
        // 6: reset during LOCK_D
        dreq = 1;
        cyc();
        ireq = 1; rstn = 0;
        #1;
        cmp("t6_mreq_rst", 64'(mreq), 64'd0);
        cmp("t6_owner_rst", 64'(owner), 64'd0);
        cyc();
        dreq = 0; rstn = 1;
        lit();
        cmp("t6_owner_rel", 64'(owner), 64'd1);
        cyc();
        ireq = 0;
        cyc();
        // Randomized traffic; requesters hold fields stable until granted.
        for (int n = 0; n < 3000; n++) begin
            if (e_done && e_own == 1) ireq = 0;
            if (e_done && e_own == 2) dreq = 0;
            if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1; iaddr = {$urandom, $urandom}; iwen = 1'($urandom);
                istrb = 8'($urandom); iwdata = {$urandom, $urandom};
            end
            if (!dreq && $urandom_range(0, 3) != 0) begin
                dreq = 1; daddr = {$urandom, $urandom}; dwen = 1'($urandom);
                dstrb = 8'($urandom); dwdata = {$urandom, $urandom};
            end
            mgnt = $urandom_range(0, 2) != 0;
            merr = 1'($urandom);
            mrdata = {$urandom, $urandom};
            rstn = $urandom_range(0, 150) != 0;
            cyc();
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
